// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: IF/ID control codes, fetch state
// encoding, NOP encoding and the IF/ID bundle type.
package fetch_stage_pkg;

    localparam logic [1:0] DATA_CTRL_NORMAL = 2'b00;
    localparam logic [1:0] DATA_CTRL_STOP   = 2'b01;
    localparam logic [1:0] DATA_CTRL_FLUSH  = 2'b10;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: pipeline stage register driven by a NORMAL/STOP/FLUSH code.
// Ports: clk_i, rst_i (async high), ctrl_i, d_i (bundle in), q_o (bundle out).
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] ctrl_i,
    input  if_id_t     d_i,
    output if_id_t     q_o
);

    localparam if_id_t BUBBLE = '{
        pc:    32'd0,
        pc4:   32'd0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

    // Reserved code 2'b11 is treated as a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= BUBBLE;
        end else begin
            unique case (1'b1)
                (ctrl_i == DATA_CTRL_NORMAL): q_o <= d_i;
                (ctrl_i == DATA_CTRL_STOP):   q_o <= q_o;
                default:                      q_o <= BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC mux, fetch FSM and IF/ID register.
// Ports: clk_i, rst_i, keep_i, back_i, back_pc_i, if_id_ctrl_i, irom_addr_o,
// irom_data_i, ID_pc_o, ID_pc4_o, ID_irom_o, ID_valid_o; with FETCH_PERF_EN
// also perf_clr_i, perf_fetch_o, perf_stall_o, perf_flush_o.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        keep_i,
    input  logic        back_i,
    input  logic [31:0] back_pc_i,
    input  logic [1:0]  if_id_ctrl_i,
    output logic [31:0] irom_addr_o,
    input  logic [31:0] irom_data_i,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_pc4_o,
    output logic [31:0] ID_irom_o,
    output logic        ID_valid_o
`ifdef FETCH_PERF_EN
    ,
    input  logic        perf_clr_i,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    fetch_state_e state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  redir_pc;
    logic         boot;
    if_id_t       id_d, id_q;

    assign boot     = (state_q == ST_BOOT);
    assign redir_pc = back_pc_i & 32'hFFFF_FFFC;

    // BOOT re-presents pc_q: the IROM word seen in BOOT was addressed
    // during reset and is discarded, so the reset PC is fetched again.
    always_comb begin
        pc_n = pc_q + 32'd4;
        priority case (1'b1)
            back_i:          pc_n = redir_pc;
            (keep_i | boot): pc_n = pc_q;
            default:         pc_n = pc_q + 32'd4;
        endcase
    end

    assign irom_addr_o = rst_i ? RESET_PC : pc_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            state_q <= ST_BOOT;
        end else begin
            pc_q    <= pc_n;
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN,
            ST_HOLD: state_n = (keep_i & ~back_i) ? ST_HOLD : ST_RUN;
            default: state_n = ST_RUN;
        endcase
    end

    always_comb begin
        id_d.pc    = pc_q;
        id_d.pc4   = pc_q + 32'd4;
        id_d.instr = boot ? NOP_INSTR : irom_data_i;
        id_d.valid = ~boot;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ctrl_i (if_id_ctrl_i),
        .d_i    (id_d),
        .q_o    (id_q)
    );

    assign ID_pc_o    = id_q.pc;
    assign ID_pc4_o   = id_q.pc4;
    assign ID_irom_o  = id_q.instr;
    assign ID_valid_o = id_q.valid;

`ifdef FETCH_PERF_EN
    logic fetch_hit, stall_hit, flush_hit;

    assign fetch_hit = (if_id_ctrl_i == DATA_CTRL_NORMAL) & ~boot;
    assign stall_hit = keep_i & ~back_i;
    assign flush_hit = if_id_ctrl_i[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetch_o <= 32'd0;
            perf_stall_o <= 32'd0;
            perf_flush_o <= 32'd0;
        end else if (perf_clr_i) begin
            perf_fetch_o <= 32'd0;
            perf_stall_o <= 32'd0;
            perf_flush_o <= 32'd0;
        end else begin
            if (fetch_hit) perf_fetch_o <= sat_inc(perf_fetch_o);
            if (stall_hit) perf_stall_o <= sat_inc(perf_stall_o);
            if (flush_hit) perf_flush_o <= sat_inc(perf_flush_o);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: vector table with scoreboard queue,
// plus hand sequences for reset, wrap and perf counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep;
    logic        back;
    logic [31:0] back_pc;
    logic [1:0]  ctrl;

    logic [31:0] addr, data, id_pc, id_pc4, id_irom;
    logic        id_valid;
    logic [31:0] w_addr, w_data, w_pc, w_pc4, w_irom;
    logic        w_valid;

`ifdef FETCH_PERF_EN
    logic        perf_clr;
    logic [31:0] p_fetch, p_stall, p_flush;
    logic [31:0] wp_fetch, wp_stall, wp_flush;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .keep_i       (keep),
        .back_i       (back),
        .back_pc_i    (back_pc),
        .if_id_ctrl_i (ctrl),
        .irom_addr_o  (addr),
        .irom_data_i  (data),
        .ID_pc_o      (id_pc),
        .ID_pc4_o     (id_pc4),
        .ID_irom_o    (id_irom),
        .ID_valid_o   (id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_clr_i   (perf_clr),
        .perf_fetch_o (p_fetch),
        .perf_stall_o (p_stall),
        .perf_flush_o (p_flush)
`endif
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk_i        (clk),
        .rst_i        (rst),
        .keep_i       (keep),
        .back_i       (back),
        .back_pc_i    (back_pc),
        .if_id_ctrl_i (ctrl),
        .irom_addr_o  (w_addr),
        .irom_data_i  (w_data),
        .ID_pc_o      (w_pc),
        .ID_pc4_o     (w_pc4),
        .ID_irom_o    (w_irom),
        .ID_valid_o   (w_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_clr_i   (perf_clr),
        .perf_fetch_o (wp_fetch),
        .perf_stall_o (wp_stall),
        .perf_flush_o (wp_flush)
`endif
    );

    // IROM models: one-cycle latency, word = its own address.
    always_ff @(posedge clk) data   <= addr;
    always_ff @(posedge clk) w_data <= w_addr;

    // STOP without keep drops a word: a controller violation.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(ctrl == 2'b01 && !keep))
            else $error("controller: STOP without keep");
        end
    end

    typedef struct {
        logic        keep;
        logic        back;
        logic [31:0] bpc;
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } id_exp_t;

    vec_t    vecs[$];
    id_exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic k, input logic b, input logic [31:0] bpc,
                        input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] ins, input logic v);
        vec_t t;
        t.keep = k; t.back = b; t.bpc = bpc; t.ctrl = c; t.addr = a;
        t.pc = pc; t.pc4 = pc4; t.instr = ins; t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic step(input logic k, input logic b, input logic [31:0] bpc,
                        input logic [1:0] c);
        keep = k; back = b; back_pc = bpc; ctrl = c;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wrap_exp[3];

    initial begin
        id_exp_t e;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        //   k  b  bpc      ctrl   addr     pc       pc4      instr    v
        addv(0, 0, 32'h0,   2'b00, 32'h000, 32'h000, 32'h004, 32'h013, 0);
        addv(0, 0, 32'h0,   2'b00, 32'h004, 32'h000, 32'h004, 32'h000, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h008, 32'h004, 32'h008, 32'h004, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h00C, 32'h008, 32'h00C, 32'h008, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h010, 32'h00C, 32'h010, 32'h00C, 1);
        addv(1, 0, 32'h0,   2'b01, 32'h010, 32'h00C, 32'h010, 32'h00C, 1);
        addv(1, 0, 32'h0,   2'b01, 32'h010, 32'h00C, 32'h010, 32'h00C, 1);
        addv(1, 0, 32'h0,   2'b01, 32'h010, 32'h00C, 32'h010, 32'h00C, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h014, 32'h010, 32'h014, 32'h010, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h018, 32'h014, 32'h018, 32'h014, 1);
        addv(0, 1, 32'h102, 2'b10, 32'h100, 32'h000, 32'h000, 32'h013, 0);
        addv(0, 0, 32'h0,   2'b00, 32'h104, 32'h100, 32'h104, 32'h100, 1);
        addv(1, 1, 32'h200, 2'b10, 32'h200, 32'h000, 32'h000, 32'h013, 0);
        addv(0, 0, 32'h0,   2'b00, 32'h204, 32'h200, 32'h204, 32'h200, 1);
        addv(0, 0, 32'h0,   2'b00, 32'h208, 32'h204, 32'h208, 32'h204, 1);
        addv(0, 0, 32'h0,   2'b11, 32'h20C, 32'h000, 32'h000, 32'h013, 0);
        addv(0, 0, 32'h0,   2'b00, 32'h210, 32'h20C, 32'h210, 32'h20C, 1);

`ifdef FETCH_PERF_EN
        perf_clr = 1'b0;
`endif
        // Reset with a redirect pending: it must not leak out.
        rst = 1'b1; keep = 1'b0; back = 1'b1;
        back_pc = 32'h300; ctrl = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", addr, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_id_irom", id_irom, 32'h13);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", p_fetch, 32'd0);
        chk("rst_perf_stall", p_stall, 32'd0);
        chk("rst_perf_flush", p_flush, 32'd0);
`endif
        back = 1'b0;
        rst  = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            keep = vecs[i].keep; back = vecs[i].back;
            back_pc = vecs[i].bpc; ctrl = vecs[i].ctrl;
            #1;
            chk($sformatf("v%0d_addr", i), addr, vecs[i].addr);
            e.pc = vecs[i].pc; e.pc4 = vecs[i].pc4;
            e.instr = vecs[i].instr; e.valid = vecs[i].valid;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_pc", i), id_pc, e.pc);
            chk($sformatf("v%0d_pc4", i), id_pc4, e.pc4);
            chk($sformatf("v%0d_irom", i), id_irom, e.instr);
            chk($sformatf("v%0d_valid", i), {31'd0, id_valid},
                {31'd0, e.valid});
            if (i >= 1 && i <= 3) begin
                chk($sformatf("wrap%0d_pc", i), w_pc, wrap_exp[i-1]);
                chk($sformatf("wrap%0d_valid", i), {31'd0, w_valid}, 32'd1);
            end
        end

`ifdef FETCH_PERF_EN
        chk("run_perf_fetch", p_fetch, 32'd10);
        chk("run_perf_stall", p_stall, 32'd3);
        chk("run_perf_flush", p_flush, 32'd3);
`endif

        // Asynchronous reset in the middle of a stall.
        step(1, 0, 32'h0, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst_addr", addr, 32'h0);
        chk("midrst_id_pc", id_pc, 32'h0);
        chk("midrst_id_irom", id_irom, 32'h13);
        chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf_fetch", p_fetch, 32'd0);
        chk("midrst_perf_stall", p_stall, 32'd0);
        chk("midrst_perf_flush", p_flush, 32'd0);
`endif
        keep = 1'b0; ctrl = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef FETCH_PERF_EN
        step(0, 0, 32'h0, 2'b00);
        repeat (5) step(0, 0, 32'h0, 2'b00);
        repeat (2) step(1, 0, 32'h0, 2'b01);
        step(0, 0, 32'h0, 2'b10);
        chk("perf_fetch_5", p_fetch, 32'd5);
        chk("perf_stall_2", p_stall, 32'd2);
        chk("perf_flush_1", p_flush, 32'd1);
        perf_clr = 1'b1;
        step(1, 0, 32'h0, 2'b01);
        perf_clr = 1'b0;
        chk("perf_clr_stall", p_stall, 32'd0);
        chk("perf_clr_fetch", p_fetch, 32'd0);
        step(1, 0, 32'h0, 2'b01);
        chk("perf_stall_after_clr", p_stall, 32'd1);
        rst = 1'b1;
        #1;
        chk("perf_async_rst", p_stall, 32'd0);
        keep = 1'b0; ctrl = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage with program counter. Consumes the pipeline hazard controller's hold, redirect and IF/ID control codes.
- Drives the synchronous IROM address, which has one-cycle read latency.
- Owns the IF/ID pipeline register and presents PC, PC+4, instruction and valid to the ID stage.
- Sits between the IROM and the decode stage, on the receiving end of the stall/flush protocol.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013: instruction word inserted on flush/bubble.

Ports:
- clk_i  in  1  core clock. One clock only.
- rst_i  in  1  reset, asynchronous, active-high.
- keep_i  in  1  hold PC (hazard stall).
- back_i  in  1  redirect request (taken branch/jump).
- back_pc_i  in  32  redirect target.
- if_id_ctrl_i  in  2  IF/ID register control: DATA_CTRL_NORMAL / _STOP / _FLUSH.
- irom_addr_o  out  32  IROM byte address (next PC, combinational).
- irom_data_i  in  32  IROM data for the address presented in the previous cycle.
- ID_pc_o  out  32  PC of the instruction in ID.
- ID_pc4_o  out  32  ID_pc_o + 4.
- ID_irom_o  out  32  instruction in ID.
- ID_valid_o  out  1  ID holds a real instruction.
- perf_clr_i  in  1  clear perf counters (FETCH_PERF_EN only).
- perf_fetch_o, perf_stall_o, perf_flush_o  out  32 each  perf counters (FETCH_PERF_EN only).

## Operation
Next PC (pc_n), in priority order:
- back_i → {back_pc_i[31:2], 2'b00}.
- keep_i → pc_q.
- otherwise → pc_q + 4, mod 2^32.

PC and IROM address:
- irom_addr_o = pc_n, so irom_data_i is always the word at pc_q.
- pc_q <= pc_n every cycle.

State machine:
- BOOT: entered on reset; IROM data not yet valid. Always → RUN after one cycle.
- RUN: normal fetch.
- HOLD: entered when keep_i & !back_i.
  - Stays while that holds.
  - Exits to RUN on !keep_i or back_i.
  - HOLD affects only the perf stall count; datapath behaviour is the same as RUN.

IF/ID register, decoded from if_id_ctrl_i:
- NORMAL: capture {pc_q, pc_q+4, irom_data_i}. ID_valid_o <= (state != BOOT).
  - In BOOT, ID_irom_o <= NOP_INSTR.
- STOP: hold all ID outputs.
- FLUSH, and reserved code 2'b11: ID_irom_o <= NOP_INSTR, ID_valid_o <= 0, ID_pc_o/ID_pc4_o <= 0.

Consistency rules:
- keep_i and if_id_ctrl_i are obeyed independently. The controller must pair keep_i=1 with STOP.
- STOP with keep_i=0 drops the word at pc_q. This is a controller violation and is flagged by a bench assertion, not masked.

## Timing
- Reset values:
  - pc_q = RESET_PC; irom_addr_o = RESET_PC while rst_i is high.
  - ID_pc_o = 0, ID_pc4_o = 0, ID_irom_o = NOP_INSTR, ID_valid_o = 0.
  - state = BOOT; all perf counters 0.
- Latency: an address is presented in cycle t. pc_q and irom_data_i match it in t+1. ID outputs show it in t+2.
- Redirect: back_i in cycle t, with FLUSH from the controller.
  - ID holds a bubble in t+1.
  - The target instruction is on ID outputs in t+2.
  - No wrong-path instruction ever reaches ID with ID_valid_o=1.
- Simultaneous back_i and keep_i: back_i wins.
- PC wrap: 32'hFFFF_FFFC → 32'h0000_0000, with no flag.
- Reset mid-stall or mid-redirect returns everything to reset values immediately; no pending redirect survives.

## Configuration
- FETCH_PERF_EN defined: three 32-bit counters, each saturating at 32'hFFFF_FFFF.
  - perf_fetch_o: +1 per NORMAL capture with resulting ID_valid_o=1.
  - perf_stall_o: +1 per cycle with keep_i & !back_i.
  - perf_flush_o: +1 per cycle of FLUSH/2'b11.
  - perf_clr_i is a synchronous clear. Clear and increment in the same cycle → 0.
- FETCH_PERF_EN undefined: perf ports and counters are absent; all other behaviour is identical.

## Structure
- Shared defines file/package holds:
  - DATA_CTRL_NORMAL = 2'b00, DATA_CTRL_STOP = 2'b01, DATA_CTRL_FLUSH = 2'b10.
  - The fetch state encoding.
  - The NOP encoding.
- The IF/ID register is a separate sub-module, if_id_reg. It takes the ctrl code and data, and is reusable for the other stage registers.
- PC, next-PC mux, FSM and counters stay in fetch_stage.

## Test plan
- Reset release, RESET_PC=0, IROM returns data = address.
  - ID_valid_o is 0 in the BOOT-capture cycle.
  - Then ID_pc_o = 0, 4, 8 with ID_irom_o equal to ID_pc_o.
- keep_i=1 with STOP for 3 cycles while pc_q=0x10.
  - irom_addr_o holds 0x10 and ID holds 0x0C.
  - After release, ID shows 0x10 then 0x14, with no loss or duplication.
- back_i with back_pc_i=0x102 and FLUSH.
  - Next cycle: ID_valid_o=0 and ID_irom_o=0x0000_0013.
  - Following cycle: ID_pc_o=0x100 and ID_pc4_o=0x104.
- back_i and keep_i in the same cycle, back_pc_i=0x200 → irom_addr_o=0x200 in that cycle; ID_pc_o=0x200 two cycles later.
- RESET_PC=0xFFFF_FFF8 → ID_pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- FETCH_PERF_EN: 5 valid fetches, 2 stall cycles, 1 flush → counters 5/2/1.
  - perf_clr_i together with a stall cycle → perf_stall_o=0.
  - Async reset mid-run clears all counters.
